// File: rtl/cla_serial_ctrl.sv
// Digit-serial WIDTH-bit add/subtract over one shared 4-bit carry-lookahead slice, LSB nibble first.
// Result valid NIB=WIDTH/4 cycles after accept; out_ready low holds DONE and all outputs indefinitely.

module cla_04 (
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       sub_flag,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [3:0] b_eff;
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] c;

    always_comb begin
        b_eff = src2 ^ {4{sub_flag}};
        gen   = src1 & b_eff;
        prop  = src1 ^ b_eff;

        // Every carry is a flat sum of products, so no ripple through the slice.
        c[0] = carry_in;
        c[1] = gen[0] | (prop[0] & carry_in);
        c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_in);
        c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & carry_in);
        c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & carry_in);

        sum       = prop ^ c[3:0];
        carry_out = c[4];
    end

endmodule

module cla_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_sum;
    logic             slice_co;

    always_comb begin
        a_nib = 4'd0;
        b_nib = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (k_q == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    cla_04 u_slice (
        .src1      (a_nib),
        .src2      (b_nib),
        .sub_flag  (sub_q),
        .carry_in  (cy_q),
        .sum       (slice_sum),
        .carry_out (slice_co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cy_d    = cy_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        res_d   = res_q;
        co_d    = co_q;
        ov_d    = ov_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    sub_d   = sub_flag;
                    // Carry-in of 1 completes the two's complement of the inverted src2.
                    cy_d    = sub_flag;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (k_q == CW'(i)) begin
                        res_d[4*i +: 4] = slice_sum;
                    end
                end
                cy_d = slice_co;
                if (k_q == CW'(NIB - 1)) begin
                    // Use res_d so the MSB nibble written this cycle feeds the overflow test.
                    co_d    = slice_co;
                    ov_d    = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q))
                            && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cy_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cy_q    <= cy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_cla_serial_ctrl.sv
// Directed vector table, backpressure and mid-run reset sequences, then random operands with stalls.
module tb_cla_serial_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         sub_flag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    always #5 clk = ~clk;

    cla_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .sub_flag  (sub_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Independent reference: plain integer arithmetic, signed range test for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] t;
        int         sa, sb, sr;
        logic       co, ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            t  = {1'b0, a} - {1'b0, b};
            co = (a >= b);
            sr = sa - sb;
        end else begin
            t  = {1'b0, a} + {1'b0, b};
            co = t[W];
            sr = sa + sb;
        end
        ov = (sr > 32767) || (sr < -32768);
        return {t[W-1:0], co, ov};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int stall,
                          output logic [W-1:0] r, output logic co, output logic ov, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        src1      = a;
        src2      = b;
        sub_flag  = s;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = 16'($urandom);
        src2     = 16'($urandom);
        sub_flag = ~s;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = result;
        co = carry_out;
        ov = overflow;
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] r;
        logic         co, ov;
        int           lat;
        logic [W+1:0] m;
        logic         saw_valid;
        int           rnd_bad;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hA5C3, 16'h5A3D, 1'b0, 16'h0000, 1'b1, 1'b0};

        n_rst     = 1'b0;
        in_valid  = 1'b0;
        src1      = '0;
        src2      = '0;
        sub_flag  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry_out, overflow}, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 0, r, co, ov, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_carry", i), co, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_release", i), {in_ready, out_valid, busy}, 3'b100);
        end

        // Backpressure: three stalled cycles with a stray request in the middle.
        @(negedge clk);
        in_valid = 1'b1;
        src1     = 16'h1111;
        src2     = 16'h2222;
        sub_flag = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", lat, 4);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                src1     = 16'hAAAA;
                src2     = 16'h5555;
                sub_flag = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("bp_hold%0d_ctrl", i), {out_valid, in_ready, busy}, 3'b101);
            check($sformatf("bp_hold%0d_data", i), {result, carry_out, overflow}, {16'h3333, 2'b00});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release", {in_ready, out_valid}, 2'b10);
        run_op(16'h0F0F, 16'h0101, 1'b0, 0, r, co, ov, lat);
        check("bp_next_result", {r, co, ov}, {16'h1010, 2'b00});
        check("bp_next_latency", lat, 4);

        // Reset asserted during the second RUN cycle.
        @(negedge clk);
        in_valid = 1'b1;
        src1     = 16'hFFFF;
        src2     = 16'hFFFF;
        sub_flag = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_ctrl", {in_ready, out_valid, busy}, 3'b100);
        check("mid_rst_data", {result, carry_out, overflow}, 18'd0);
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_rst_no_valid", saw_valid, 0);
        @(negedge clk);
        n_rst = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, 0, r, co, ov, lat);
        check("post_rst_result", {r, co, ov}, {16'h0100, 2'b00});
        check("post_rst_latency", lat, 4);

        rnd_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            logic         s;
            int           st;
            a  = 16'($urandom);
            b  = 16'($urandom);
            s  = 1'($urandom);
            st = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            m  = model(a, b, s);
            run_op(a, b, s, st, r, co, ov, lat);
            checks++;
            if ({r, co, ov} === m && lat == 4) begin
                passed++;
            end else begin
                rnd_bad++;
                if (rnd_bad <= 10)
                    $display("FAIL rand%0d a=%0h b=%0h sub=%0b: got %0h/%0b/%0b lat %0d expected %0h/%0b/%0b lat 4",
                             i, a, b, s, r, co, ov, lat, m[W+1:2], m[1], m[0]);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
